fifo_stream_reader: RTL and testbench
=====================================

# fifo_stream_reader

Read-side drain stage for the asynchronous FIFO, running entirely in the FIFO read-clock domain. It pops words through the FIFO's `r_en`/`empty`/`data_out` port and re-presents them as a valid/ready stream backed by a 2-entry output buffer. Downstream logic can stall freely without dropping or duplicating data, and full throughput of one word per clock is sustained when the consumer is always ready.

## Interface
- `DATA_WIDTH`, 8: word width; matches the FIFO data width.
- `COUNT_WIDTH`, 16: width of the delivered-word counter.

- `clock` in 1: read-domain clock; the same clock as the FIFO `rclock`.
- `reset` in 1: synchronous, active-high; one clock; all state clears on a `clock` edge with `reset`=1.
- `fifo_empty` in 1: FIFO `empty` flag.
- `fifo_r_en` out 1: FIFO read enable; one word is popped per cycle in which it is high.
- `fifo_rdata` in DATA_WIDTH: FIFO `data_out`; valid in the cycle after `fifo_r_en` was high.
- `m_valid` out 1: output word available.
- `m_ready` in 1: consumer accepts the word; a transfer occurs when `m_valid`=1 and `m_ready`=1.
- `m_data` out DATA_WIDTH: output word; held stable while `m_valid`=1 and `m_ready`=0.
- `word_count` out COUNT_WIDTH: number of completed output transfers, modulo 2^COUNT_WIDTH.
- `busy` out 1: high when buffer occupancy is nonzero or a read is in flight.

## Operation
- **State:** buffer occupancy FSM with states EMPTY(0), ONE(1) and TWO(2); 1-bit `inflight`; 1-bit write and read pointers into the 2-entry buffer.
- **Pop (combinational):** `pop` = `m_valid` & `m_ready`.
- **Issue rule (combinational):** `fifo_r_en` = !`fifo_empty` & (occ + `inflight` − `pop` < 2). This is a combinational path from `m_ready` and `fifo_empty` to `fifo_r_en`. Under this rule the buffer never overflows.
- **Capture:** the registered `inflight` equals the previous cycle's `fifo_r_en`. When `inflight`=1, `fifo_rdata` is written at `mem[wr_ptr]` at the clock edge and `wr_ptr` toggles.
- **Output:** `m_valid` = (occ ≠ 0). `m_data` = `mem[rd_ptr]`. On `pop`, `rd_ptr` toggles and `word_count` increments.
- **Occupancy update:** occ_next = occ + `inflight` − `pop`.
  - EMPTY→ONE on capture without pop.
  - ONE→TWO on capture without pop.
  - TWO→ONE on pop without capture.
  - ONE→EMPTY on pop without capture.
  - Capture and pop in the same cycle: state unchanged.
- **Ordering:** strict FIFO order; no word is dropped or duplicated.
- **`word_count` wrap:** wraps from 2^COUNT_WIDTH−1 to 0 with no flag.
- **`busy`:** `busy` = (occ ≠ 0) | `inflight`.

## Timing
- **Reset values:**
  - Outputs: `m_valid`=0, `m_data`=0, `word_count`=0, `busy`=0.
  - Internal state: `inflight`=0, pointers=0, buffer contents=0.
  - `fifo_r_en`=0 during any cycle with `reset`=1; the issue rule is gated by !`reset`.
- **Latency:** `fifo_r_en` high in cycle t → data captured at the end of cycle t+1 → `m_valid`=1 with that word in cycle t+2.
- **Throughput:** with `m_ready` held at 1 and the FIFO non-empty, `fifo_r_en` stays high continuously and one word transfers per clock after the 2-cycle fill.
- **Stall:** with `m_ready`=0, at most 2 words are buffered. `fifo_r_en` drops once occ + `inflight` reaches 2 and resumes in the cycle `pop` occurs.
- **FIFO empty:** `fifo_r_en`=0 regardless of buffer space. An in-flight word is still captured.
- **Simultaneous capture and pop at TWO:** impossible by the issue rule. Simultaneous capture and pop at ONE: the new word is written to the free slot while the old word leaves.
- **Reset mid-operation:**
  - Buffered words are discarded.
  - An in-flight `fifo_rdata` arriving in the cycle after reset is ignored, because `inflight` was cleared.
  - The system resets the FIFO read domain together with this block.

## Test plan
- **Reset:** `reset`=1 for 3 clocks with `fifo_empty`=0 → `fifo_r_en`=0, `m_valid`=0, `m_data`=0, `word_count`=0 throughout. First `fifo_r_en` occurs in the first cycle with `reset`=0.
- **Streaming:** FIFO model holds 0x11..0x18 and `m_ready`=1 → `fifo_r_en` high for 8 consecutive cycles. `m_valid` rises 2 cycles after the first `fifo_r_en`. The 8 words appear in order on consecutive clocks; then `word_count`=8 and `busy`=0.
- **Back-pressure:** 4 words 0xA0..0xA3 queued, `m_ready`=0 for 10 cycles → exactly 2 `fifo_r_en` pulses, `m_valid`=1 and `m_data`=0xA0 stable. Raising `m_ready` then delivers 0xA0..0xA3 in order with no gaps after the first.
- **Random ready:** 64 random words written via an async FIFO model with `wclock` 20 ns and `rclock` 70 ns, with random `m_ready` → scoreboard matches all 64 in order, `word_count`=64, and occupancy never exceeds 2.
- **Reset with a word in flight:** assert `reset` in the cycle after a `fifo_r_en` pulse while occ=1 → the cycle after reset shows `m_valid`=0 and `busy`=0, the stale `fifo_rdata` is not delivered, and `word_count`=0.
- **Counter wrap:** with `COUNT_WIDTH`=4, perform 17 transfers → `word_count` reads 15 after 15 transfers, then 0, then 1.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Read-side drain stage for an asynchronous FIFO. Runs entirely in the FIFO
//   read-clock domain. Words are popped through the FIFO r_en/empty/data_out
//   port and re-presented as a valid/ready stream from a 2-entry buffer. The
//   buffer lets the consumer stall without losing or repeating data, and
//   keeps one word per clock flowing when the consumer is always ready.
//
// Ports
//   clock       in   read-domain clock (same clock as the FIFO rclock)
//   reset       in   synchronous, active-high reset
//   fifo_empty  in   FIFO empty flag
//   fifo_r_en   out  FIFO read enable, one pop per high cycle
//   fifo_rdata  in   FIFO data_out, valid the cycle after fifo_r_en
//   m_valid     out  output word available
//   m_ready     in   consumer accepts the word (transfer on valid & ready)
//   m_data      out  output word, held while m_valid=1 and m_ready=0
//   word_count  out  completed output transfers, modulo 2^COUNT_WIDTH
//   busy        out  buffer non-empty or a FIFO read in flight
module fifo_stream_reader #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   fifo_empty,
  output logic                   fifo_r_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rdata,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic [COUNT_WIDTH-1:0] word_count,
  output logic                   busy
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  occ_e                   occ_q, occ_d;
  logic                   inflight_q, inflight_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic [COUNT_WIDTH-1:0] word_count_q, word_count_d;
  logic [DATA_WIDTH-1:0]  mem_q [2];
  logic [DATA_WIDTH-1:0]  mem_d [2];

  logic                   pop;
  // Committed slots after this cycle: buffered words plus the word in
  // flight, minus the word leaving now. Three bits so occ=2 plus an
  // in-flight word cannot alias.
  logic [2:0]             level;

  assign m_valid    = (occ_q != OCC_EMPTY);
  assign m_data     = mem_q[rd_ptr_q];
  assign word_count = word_count_q;
  assign busy       = (occ_q != OCC_EMPTY) | inflight_q;

  always_comb begin
    pop   = m_valid & m_ready;
    level = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    // Crediting the pop in the same cycle is what allows back-to-back
    // reads at full rate; it makes m_ready a combinational input to r_en.
    fifo_r_en = ~reset & ~fifo_empty & (level < 3'd2);
  end

  always_comb begin
    inflight_d   = fifo_r_en;
    wr_ptr_d     = wr_ptr_q ^ inflight_q;
    rd_ptr_d     = rd_ptr_q ^ pop;
    word_count_d = word_count_q + COUNT_WIDTH'(pop);
    occ_d        = occ_q;
    case ({inflight_q, pop})
      2'b10: begin
        case (occ_q)
          OCC_EMPTY: occ_d = OCC_ONE;
          OCC_ONE:   occ_d = OCC_TWO;
          default:   occ_d = occ_q;  // capture at TWO cannot be issued
        endcase
      end
      2'b01: begin
        case (occ_q)
          OCC_TWO: occ_d = OCC_ONE;
          OCC_ONE: occ_d = OCC_EMPTY;
          default: occ_d = occ_q;    // pop needs m_valid, so never at EMPTY
        endcase
      end
      default: occ_d = occ_q;        // none, or capture and pop together
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      occ_q        <= OCC_EMPTY;
      inflight_q   <= 1'b0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      word_count_q <= '0;
    end else begin
      occ_q        <= occ_d;
      inflight_q   <= inflight_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      word_count_q <= word_count_d;
    end
  end

  // Buffer slots. A slot is written only when the returning word targets it;
  // with capture and pop at ONE the write lands in the slot not being read.
  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    always_comb begin
      mem_d[gi] = mem_q[gi];
      if (inflight_q && (wr_ptr_q == 1'(gi))) begin
        mem_d[gi] = fifo_rdata;
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        mem_q[gi] <= '0;
      end else begin
        mem_q[gi] <= mem_d[gi];
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader. A FIFO model feeds the DUT; stimulus pushes
// each word into both the FIFO model and the scoreboard; a negedge monitor
// pops the scoreboard on every transfer. A second instance with a 4-bit
// counter sees the same inputs and is checked for counter wrap.
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          wclock = 1'b0;
  logic          reset = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_rdata = '0;
  logic          m_ready = 1'b0;

  logic          fifo_r_en, m_valid, busy;
  logic [DW-1:0] m_data;
  logic [CW-1:0] word_count;

  logic          w_r_en, w_valid, w_busy;
  logic [DW-1:0] w_data;
  logic [3:0]    w_count;

  fifo_stream_reader #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .fifo_empty(fifo_empty),
    .fifo_r_en(fifo_r_en), .fifo_rdata(fifo_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .word_count(word_count), .busy(busy)
  );

  fifo_stream_reader #(.DATA_WIDTH(DW), .COUNT_WIDTH(4)) dut_w (
    .clock(clock), .reset(reset), .fifo_empty(fifo_empty),
    .fifo_r_en(w_r_en), .fifo_rdata(fifo_rdata),
    .m_valid(w_valid), .m_ready(m_ready), .m_data(w_data),
    .word_count(w_count), .busy(w_busy)
  );

  always #35 clock = ~clock;   // read clock, 70 ns
  always #10 wclock = ~wclock; // write clock, 20 ns

  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] sb_q [$];
  int            n_tests = 0;
  int            n_fail = 0;
  int            exp_cnt = 0;
  int            in_buf = 0;
  int            writer_left = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] exp_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // FIFO model: pop on r_en, data appears the next cycle; empty refreshes
  // shortly after each read edge. Also tracks words committed to the DUT.
  always @(posedge clock) begin
    if (reset) in_buf = 0;
    else in_buf = in_buf + (fifo_r_en ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
    if (fifo_r_en) begin
      if (fifo_q.size() > 0) begin
        fifo_rdata <= fifo_q.pop_front();
      end else begin
        n_tests++;
        n_fail++;
        $display("FAIL read_of_empty_fifo: got r_en=1, expected 0");
      end
    end
    #1 fifo_empty = (fifo_q.size() == 0);
  end

  // Write side of the async FIFO model.
  always @(posedge wclock) begin
    if (writer_left > 0) begin
      exp_w = 8'($urandom);
      fifo_q.push_back(exp_w);
      sb_q.push_back(exp_w);
      writer_left--;
    end
  end

  // Monitor / scoreboard.
  always @(negedge clock) begin
    check("occupancy_le_2", 32'(in_buf <= 2), 32'd1);
    check("word_count", 32'(word_count), 32'(exp_cnt[15:0]));
    check("wrap_word_count", 32'(w_count), 32'(exp_cnt[3:0]));
    if (reset) begin
      check("reset_r_en", 32'(fifo_r_en), 32'd0);
      check("reset_r_en_w", 32'(w_r_en), 32'd0);
      exp_cnt = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(m_valid), 32'd1);
        check("stall_data", 32'(m_data), 32'(prev_data));
      end
      if (m_valid && m_ready) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%0h, expected none", m_data);
        end else begin
          check("m_data", 32'(m_data), 32'(sb_q[0]));
          check("w_valid", 32'(w_valid), 32'd1);
          check("w_data", 32'(w_data), 32'(sb_q[0]));
          void'(sb_q.pop_front());
        end
        exp_cnt++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    sb_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    fifo_q.delete();
    sb_q.delete();
    fifo_empty = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_cnt(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (exp_cnt < n && k < budget) begin
      tick();
      k++;
    end
    check(name, 32'(exp_cnt >= n), 32'd1);
  endtask

  logic [11:0] ren_v, val_v, busy_v;
  logic [9:0]  bp_ren;
  logic [3:0]  bp_val;

  initial begin
    // Reset held with a non-empty FIFO.
    reset   = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(8'(8'h11 + i));
    repeat (3) begin
      @(negedge clock);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
    end
    tick();
    reset = 1'b0;

    // Streaming: r_en cycles 0..7, valid 2..9, busy 1..9.
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      ren_v[c]  = fifo_r_en;
      val_v[c]  = m_valid;
      busy_v[c] = busy;
    end
    check("stream_r_en_pattern", 32'(ren_v), 32'h0FF);
    check("stream_valid_pattern", 32'(val_v), 32'h3FC);
    check("stream_busy_pattern", 32'(busy_v), 32'h3FE);
    check("stream_count", 32'(word_count), 32'd8);
    check("stream_busy_w", 32'(w_busy), 32'd0);

    // Back-pressure: two reads only, head word held.
    tick();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'hA0 + i));
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      bp_ren[c] = fifo_r_en;
    end
    check("bp_r_en_pattern", 32'(bp_ren), 32'h003);
    check("bp_valid", 32'(m_valid), 32'd1);
    check("bp_data", 32'(m_data), 32'hA0);
    tick();
    m_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      bp_val[c] = m_valid;
    end
    check("bp_no_gaps", 32'(bp_val), 32'hF);
    @(negedge clock);
    check("bp_drained", 32'(m_valid), 32'd0);
    check("bp_count", 32'(word_count), 32'd12);

    // Reset while a word is in flight and one is buffered.
    tick();
    m_ready = 1'b0;
    push(8'h55);
    tick(); tick();
    @(negedge clock);
    check("inflight_setup_valid", 32'(m_valid), 32'd1);
    tick();
    push(8'h66);
    @(negedge clock);
    check("inflight_r_en", 32'(fifo_r_en), 32'd1);
    tick();
    reset = 1'b1;
    fifo_q.delete();
    sb_q.delete();
    fifo_empty = 1'b1;
    tick();
    reset   = 1'b0;
    m_ready = 1'b1;
    @(negedge clock);
    check("post_reset_valid", 32'(m_valid), 32'd0);
    check("post_reset_busy", 32'(busy), 32'd0);
    check("post_reset_count", 32'(word_count), 32'd0);
    repeat (4) begin
      @(negedge clock);
      check("stale_not_delivered", 32'(m_valid), 32'd0);
    end

    // Random ready with a faster write side.
    tick();
    writer_left = 64;
    for (int k = 0; k < 3000 && exp_cnt < 64; k++) begin
      tick();
      m_ready = 1'($urandom_range(0, 1));
    end
    check("random_done", 32'(exp_cnt >= 64), 32'd1);
    @(negedge clock);
    check("random_count", 32'(word_count), 32'd64);
    check("random_sb_empty", 32'(sb_q.size()), 32'd0);

    // Counter wrap on the 4-bit instance: 15, 0, 1 checked every cycle by
    // the monitor; final value confirmed here.
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 17; i++) push(8'(8'hC0 + i));
    wait_cnt(17, 200, "wrap_done");
    repeat (3) @(negedge clock);
    check("wrap_final", 32'(w_count), 32'd1);
    check("wrap_main_count", 32'(word_count), 32'd17);
    check("wrap_busy", 32'(w_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
